idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
- Decode→execute pipeline stage that sits directly downstream of maindec.
- Registers maindec's control bundle, register-file operands, the sign-extended immediate, PC and instruction fields into EX, one cycle of latency.
- Contains load-use hazard detection: inserts a bubble into EX and requests an upstream IF/ID stall.
- Applies the branch flush coming back from MEM.

Parameters:
- N, 64, datapath width of operands, immediate and PC.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- valid_d  in  1  decode slot holds a real instruction
- instr_d  in  32  decoded instruction; fields used: [31:21] funct, [20:16] Rm, [9:5] Rn, [4:0] Rt/Rd
- reg2loc_d, alusrc_d, memtoreg_d, regwrite_d, memread_d, memwrite_d, branch_d  in  1 each  maindec control outputs
- aluop_d  in  2  maindec ALUOp
- pc_d  in  N  PC of decode instruction
- rd1_d, rd2_d  in  N  register-file read data
- signimm_d  in  N  sign-extended immediate
- flush_e  in  1  branch taken (PCSrc from MEM); squash the instruction entering EX
- stall_fd  out  1  combinational; hold PC and IF/ID this cycle
- valid_e  out  1  EX slot holds a real instruction
- ctrl_e  out  10  registered {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0], 2'b00 reserved}
- funct_e  out  11  registered instr_d[31:21], feeds aludec
- pc_e, rd1_e, rd2_e, signimm_e  out  N each  registered copies
- rd_e  out  5  registered instr_d[4:0]

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every registered output is 0, so valid_e=0, ctrl_e=0 and rd_e=0. stall_fd is 0 while reset is high.
- Source use:
  - ra = instr_d[9:5], used when ~branch_d.
  - rb = reg2loc_d ? instr_d[4:0] : instr_d[20:16], used when ~alusrc_d | memwrite_d | branch_d.
- Hazard: hz = valid_d & valid_e & ctrl_e.memread & ((use_ra & ra==rd_e) | (use_rb & rb==rd_e)).
- stall_fd = hz & ~flush_e (combinational, no added latency).
- Register update priority per rising edge:
  1. flush_e=1: valid_e←0, ctrl_e←0, data fields←0. Flush overrides a simultaneous hazard; no stall is issued.
  2. hz=1: bubble. valid_e←0, ctrl_e←0, data fields←0; the decode instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture all _d inputs. valid_e←valid_d; ctrl_e←valid_d ? controls : 0.
- A bubble always has ctrl_e=0, so regwrite/memwrite/memread/branch are never asserted for an invalid slot.
- A hazard lasts exactly one cycle: after the bubble, valid_e=0, so hz falls.
- Back-to-back loads are handled by the same rule with no special case.
- rd_e=31 matches like any register unless the optional feature is enabled.
- No combinational path from any _d input to a registered output.

Optional Feature:
- Macro: IDEX_XZR_FILTER_EN
- Defined: comparisons against register 31 (XZR) never raise hz, since an LDUR to XZR produces no dependency.
- Undefined: X31 is compared like any other register, which can cause a conservative extra bubble.

Decomposition:
- Package idex_pkg:
  - typedef ctrl_t, a packed struct with the control field order above;
  - localparams XZR=5'd31, ALUOP_LDST=2'b00, ALUOP_CBZ=2'b01, ALUOP_R=2'b10;
  - instruction field bit-position constants.
- Sub-module hazard_unit: purely combinational. Inputs are the decode fields, the control bits, valid_e, memread_e and rd_e; output is hz. It holds the only #ifdef for the optional feature.
- idex_stage holds the registers and the priority logic.

Test Plan:
- Reset mid-operation: load valid ADD, assert reset between edges → all outputs 0 immediately, stall_fd=0.
- Plain capture: ADD (op 100_0101_1000, Rn=2, Rm=3, Rd=1), regwrite=1, aluop=10 → next edge valid_e=1, funct_e=11'h458, rd_e=1, ctrl_e.regwrite=1, no stall.
- Load-use:
  - Stimulus: LDUR X5 (op 111_1100_0010) in EX, then ADD reading Rn=5.
  - stall_fd=1 for exactly one cycle and EX gets a bubble (valid_e=0, ctrl_e=0).
  - The ADD enters EX on the following edge.
- Store data dependency: LDUR X7 in EX, then STUR with Rt=7 (reg2loc=1, alusrc=1, memwrite=1) → stall_fd=1. The same STUR with Rt=8 → no stall.
- Flush priority: hazard condition present and flush_e=1 on the same cycle → stall_fd=0, next edge valid_e=0, ctrl_e=0.
- XZR:
  - Stimulus: LDUR X31 in EX, then ADD with Rn=31.
  - With IDEX_XZR_FILTER_EN: no stall.
  - Without it: one bubble.

Source files
------------

// File: rtl/idex_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
package idex_pkg;

    // Control bundle carried into EX; field order matches the ctrl_e bus, MSB first.
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic [1:0] rsvd;
    } ctrl_t;

    localparam logic [4:0] XZR        = 5'd31;
    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_CBZ  = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;

    // Instruction field bit positions
    localparam int FUNCT_HI = 31;
    localparam int FUNCT_LO = 21;
    localparam int RM_HI    = 20;
    localparam int RM_LO    = 16;
    localparam int RN_HI    = 9;
    localparam int RN_LO    = 5;
    localparam int RT_HI    = 4;
    localparam int RT_LO    = 0;

endpackage

// File: rtl/idex_hazard_unit.sv
// Load-use hazard detection between the decode slot and a load sitting in EX.
// Optional macro IDEX_XZR_FILTER_EN: a load targeting XZR never raises a hazard.
module hazard_unit
    import idex_pkg::*;
(
    input  logic       valid_d,
    input  logic [4:0] rn,
    input  logic [4:0] rm,
    input  logic [4:0] rt,
    input  logic       reg2loc,
    input  logic       alusrc,
    input  logic       memwrite,
    input  logic       branch,
    input  logic       valid_e,
    input  logic       memread_e,
    input  logic [4:0] rd_e,
    output logic       hz
);

    logic [4:0] ra;
    logic [4:0] rb;
    logic       use_ra;
    logic       use_rb;
    logic       rd_live;

    assign ra     = rn;
    assign rb     = reg2loc ? rt : rm;
    assign use_ra = ~branch;
    // Stores read Rt as data and CBZ reads Rt as the tested value
    assign use_rb = ~alusrc | memwrite | branch;

`ifdef IDEX_XZR_FILTER_EN
    // Writes to XZR are discarded, so a load into it creates no dependency
    assign rd_live = (rd_e != XZR);
`else
    assign rd_live = 1'b1;
`endif

    // Compare decode sources against the destination of the load in EX
    always_comb begin
        hz = valid_d & valid_e & memread_e & rd_live &
             ((use_ra & (ra == rd_e)) | (use_rb & (rb == rd_e)));
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional macro IDEX_XZR_FILTER_EN (handled inside hazard_unit).
module idex_stage
    import idex_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_d,
    input  logic [31:0]  instr_d,
    input  logic         reg2loc_d,
    input  logic         alusrc_d,
    input  logic         memtoreg_d,
    input  logic         regwrite_d,
    input  logic         memread_d,
    input  logic         memwrite_d,
    input  logic         branch_d,
    input  logic [1:0]   aluop_d,
    input  logic [N-1:0] pc_d,
    input  logic [N-1:0] rd1_d,
    input  logic [N-1:0] rd2_d,
    input  logic [N-1:0] signimm_d,
    input  logic         flush_e,
    output logic         stall_fd,
    output logic         valid_e,
    output logic [9:0]   ctrl_e,
    output logic [10:0]  funct_e,
    output logic [N-1:0] pc_e,
    output logic [N-1:0] rd1_e,
    output logic [N-1:0] rd2_e,
    output logic [N-1:0] signimm_e,
    output logic [4:0]   rd_e
);

    ctrl_t        ctrl_reg;
    ctrl_t        ctrl_d;
    logic         valid_reg;
    logic [10:0]  funct_reg;
    logic [4:0]   rd_reg;
    logic [N-1:0] pc_reg;
    logic [N-1:0] rd1_reg;
    logic [N-1:0] rd2_reg;
    logic [N-1:0] signimm_reg;
    logic         hz;
    logic         unused_bits;

    // Immediate/shamt bits are consumed downstream via signimm_d, not here
    assign unused_bits = ^instr_d[15:10];

    assign ctrl_d = '{alusrc:   alusrc_d,
                      memtoreg: memtoreg_d,
                      regwrite: regwrite_d,
                      memread:  memread_d,
                      memwrite: memwrite_d,
                      branch:   branch_d,
                      aluop:    aluop_d,
                      rsvd:     2'b00};

    hazard_unit u_hazard (
        .valid_d   (valid_d),
        .rn        (instr_d[RN_HI:RN_LO]),
        .rm        (instr_d[RM_HI:RM_LO]),
        .rt        (instr_d[RT_HI:RT_LO]),
        .reg2loc   (reg2loc_d),
        .alusrc    (alusrc_d),
        .memwrite  (memwrite_d),
        .branch    (branch_d),
        .valid_e   (valid_reg),
        .memread_e (ctrl_reg.memread),
        .rd_e      (rd_reg),
        .hz        (hz)
    );

    // A flush squashes the hazard too, so no stall is requested under flush
    assign stall_fd = hz & ~flush_e;

    // Pipeline register: flush beats bubble beats normal capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            funct_reg   <= '0;
            rd_reg      <= '0;
            pc_reg      <= '0;
            rd1_reg     <= '0;
            rd2_reg     <= '0;
            signimm_reg <= '0;
        end else if (flush_e || hz) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            funct_reg   <= '0;
            rd_reg      <= '0;
            pc_reg      <= '0;
            rd1_reg     <= '0;
            rd2_reg     <= '0;
            signimm_reg <= '0;
        end else begin
            valid_reg   <= valid_d;
            ctrl_reg    <= valid_d ? ctrl_d : '0;
            funct_reg   <= instr_d[FUNCT_HI:FUNCT_LO];
            rd_reg      <= instr_d[RT_HI:RT_LO];
            pc_reg      <= pc_d;
            rd1_reg     <= rd1_d;
            rd2_reg     <= rd2_d;
            signimm_reg <= signimm_d;
        end
    end

    assign valid_e   = valid_reg;
    assign ctrl_e    = ctrl_reg;
    assign funct_e   = funct_reg;
    assign rd_e      = rd_reg;
    assign pc_e      = pc_reg;
    assign rd1_e     = rd1_reg;
    assign rd2_e     = rd2_reg;
    assign signimm_e = signimm_reg;

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage.
module tb_idex_stage;

    localparam int N = 64;

    // ctrl_e images: {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop, 00}
    localparam logic [9:0] C_ADD  = 10'b0010001000;
    localparam logic [9:0] C_LDUR = 10'b1111000000;
    localparam logic [9:0] C_STUR = 10'b1000100000;
    localparam logic [9:0] C_CBZ  = 10'b0000010100;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_CBZ  = 11'h5A0;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_d;
    logic [31:0]  instr_d;
    logic         reg2loc_d, alusrc_d, memtoreg_d, regwrite_d;
    logic         memread_d, memwrite_d, branch_d;
    logic [1:0]   aluop_d;
    logic [N-1:0] pc_d, rd1_d, rd2_d, signimm_d;
    logic         flush_e;
    logic         stall_fd;
    logic         valid_e;
    logic [9:0]   ctrl_e;
    logic [10:0]  funct_e;
    logic [N-1:0] pc_e, rd1_e, rd2_e, signimm_e;
    logic [4:0]   rd_e;

    int checks   = 0;
    int failures = 0;

    idex_stage #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_d    (valid_d),
        .instr_d    (instr_d),
        .reg2loc_d  (reg2loc_d),
        .alusrc_d   (alusrc_d),
        .memtoreg_d (memtoreg_d),
        .regwrite_d (regwrite_d),
        .memread_d  (memread_d),
        .memwrite_d (memwrite_d),
        .branch_d   (branch_d),
        .aluop_d    (aluop_d),
        .pc_d       (pc_d),
        .rd1_d      (rd1_d),
        .rd2_d      (rd2_d),
        .signimm_d  (signimm_d),
        .flush_e    (flush_e),
        .stall_fd   (stall_fd),
        .valid_e    (valid_e),
        .ctrl_e     (ctrl_e),
        .funct_e    (funct_e),
        .pc_e       (pc_e),
        .rd1_e      (rd1_e),
        .rd2_e      (rd2_e),
        .signimm_e  (signimm_e),
        .rd_e       (rd_e)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [4:0] rm,
                                       input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'b000000, rn, rd};
    endfunction

    // Present one decode slot; ctrl uses the ctrl_e bit layout
    task automatic drive(input logic v, input logic [31:0] ins, input logic r2l,
                         input logic [9:0] c);
        valid_d    = v;
        instr_d    = ins;
        reg2loc_d  = r2l;
        alusrc_d   = c[9];
        memtoreg_d = c[8];
        regwrite_d = c[7];
        memread_d  = c[6];
        memwrite_d = c[5];
        branch_d   = c[4];
        aluop_d    = c[3:2];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 10'h0);
        flush_e = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd2, 5'd1), 1'b0, C_ADD);
        pc_d = 64'h100; rd1_d = 64'h11; rd2_d = 64'h22; signimm_d = 64'h33;
        tick();
        checks++;
        if (valid_e !== 1'b1) begin
            failures++;
            $display("FAIL reset_preload valid_e got=%0b exp=1", valid_e);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({valid_e, ctrl_e, rd_e, funct_e, pc_e, rd1_e} !== '0) begin
            failures++;
            $display("FAIL reset_async valid=%0b ctrl=%h rd=%0d funct=%h pc=%h rd1=%h exp all 0",
                     valid_e, ctrl_e, rd_e, funct_e, pc_e, rd1_e);
        end
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%0b exp=0", stall_fd);
        end
        drive(1'b0, 32'h0, 1'b0, 10'h0);
        #1 reset = 1'b0;
        tick();
        $display("reset: valid_e=%0b ctrl_e=%h stall_fd=%0b", valid_e, ctrl_e, stall_fd);
    endtask

    task automatic test_capture();
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd2, 5'd1), 1'b0, C_ADD);
        pc_d = 64'hDEAD_0000_0000_1000; rd1_d = 64'h5; rd2_d = 64'h7; signimm_d = 64'hFFFF_FFFF_FFFF_FFF0;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL capture_stall got=%0b exp=0", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || funct_e !== 11'h458 || rd_e !== 5'd1 || ctrl_e !== C_ADD) begin
            failures++;
            $display("FAIL capture_ctrl valid=%0b funct=%h rd=%0d ctrl=%h exp 1/458/1/%h",
                     valid_e, funct_e, rd_e, ctrl_e, C_ADD);
        end
        checks++;
        if (pc_e !== 64'hDEAD_0000_0000_1000 || rd1_e !== 64'h5 || rd2_e !== 64'h7 ||
            signimm_e !== 64'hFFFF_FFFF_FFFF_FFF0) begin
            failures++;
            $display("FAIL capture_data pc=%h rd1=%h rd2=%h imm=%h", pc_e, rd1_e, rd2_e, signimm_e);
        end
        // Invalid decode slot: controls must not leak into EX
        drive(1'b0, mk(OP_LDUR, 5'd0, 5'd1, 5'd9), 1'b0, C_LDUR);
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 10'h0) begin
            failures++;
            $display("FAIL capture_invalid valid=%0b ctrl=%h exp 0/000", valid_e, ctrl_e);
        end
        $display("capture: funct_e=%h rd_e=%0d ctrl_e=%h", funct_e, rd_e, ctrl_e);
    endtask

    task automatic test_load_use();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd5), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd5, 5'd6), 1'b0, C_ADD);
        pc_d = 64'h204;
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_stall got=%0b exp=1", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 10'h0 || pc_e !== '0 || stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_bubble valid=%0b ctrl=%h pc=%h stall=%0b exp 0/000/0/0",
                     valid_e, ctrl_e, pc_e, stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd6 || ctrl_e !== C_ADD || pc_e !== 64'h204) begin
            failures++;
            $display("FAIL loaduse_enter valid=%0b rd=%0d ctrl=%h pc=%h exp 1/6/%h/204",
                     valid_e, rd_e, ctrl_e, pc_e, C_ADD);
        end
        $display("load_use: valid_e=%0b rd_e=%0d", valid_e, rd_e);
        idle();
    endtask

    task automatic test_store_dep();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd7), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_STUR, 5'd0, 5'd2, 5'd7), 1'b1, C_STUR);
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL store_rt7 got=%0b exp=1", stall_fd);
        end
        drive(1'b1, mk(OP_STUR, 5'd0, 5'd2, 5'd8), 1'b1, C_STUR);
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL store_rt8 got=%0b exp=0", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || ctrl_e !== C_STUR || rd_e !== 5'd8) begin
            failures++;
            $display("FAIL store_enter valid=%0b ctrl=%h rd=%0d exp 1/%h/8", valid_e, ctrl_e, rd_e, C_STUR);
        end
        $display("store_dep: ctrl_e=%h rd_e=%0d", ctrl_e, rd_e);
        idle();
    endtask

    task automatic test_cbz_no_ra();
        // CBZ ignores bits [9:5], so a match there must not stall; a match on Rt must
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd4), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_CBZ, 5'd0, 5'd4, 5'd9), 1'b1, C_CBZ);
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL cbz_rn_ignored got=%0b exp=0", stall_fd);
        end
        drive(1'b1, mk(OP_CBZ, 5'd0, 5'd9, 5'd4), 1'b1, C_CBZ);
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL cbz_rt_used got=%0b exp=1", stall_fd);
        end
        $display("cbz: stall_fd=%0b", stall_fd);
        idle();
    endtask

    task automatic test_flush();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd5), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd5, 5'd6), 1'b0, C_ADD);
        flush_e = 1'b1;
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%0b exp=0", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 10'h0) begin
            failures++;
            $display("FAIL flush_squash valid=%0b ctrl=%h exp 0/000", valid_e, ctrl_e);
        end
        $display("flush: valid_e=%0b ctrl_e=%h", valid_e, ctrl_e);
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd5), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd5, 5'd6), 1'b0, C_LDUR);
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_stall got=%0b exp=1", stall_fd);
        end
        tick();
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd6 || ctrl_e !== C_LDUR) begin
            failures++;
            $display("FAIL b2b_second_load valid=%0b rd=%0d ctrl=%h exp 1/6/%h", valid_e, rd_e, ctrl_e, C_LDUR);
        end
        drive(1'b1, mk(OP_ADD, 5'd6, 5'd2, 5'd3), 1'b0, C_ADD);
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL b2b_rm_stall got=%0b exp=1", stall_fd);
        end
        $display("back_to_back: rd_e=%0d stall_fd=%0b", rd_e, stall_fd);
        idle();
    endtask

    task automatic test_xzr();
        drive(1'b1, mk(OP_LDUR, 5'd0, 5'd1, 5'd31), 1'b0, C_LDUR);
        tick();
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd31, 5'd2), 1'b0, C_ADD);
`ifdef IDEX_XZR_FILTER_EN
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL xzr_filtered got=%0b exp=0", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd2) begin
            failures++;
            $display("FAIL xzr_enter valid=%0b rd=%0d exp 1/2", valid_e, rd_e);
        end
`else
        checks++;
        if (stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL xzr_stall got=%0b exp=1", stall_fd);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 10'h0) begin
            failures++;
            $display("FAIL xzr_bubble valid=%0b ctrl=%h exp 0/000", valid_e, ctrl_e);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd2) begin
            failures++;
            $display("FAIL xzr_enter valid=%0b rd=%0d exp 1/2", valid_e, rd_e);
        end
`endif
        $display("xzr: valid_e=%0b rd_e=%0d", valid_e, rd_e);
        idle();
    endtask

    initial begin
        reset     = 1'b1;
        flush_e   = 1'b0;
        pc_d      = '0;
        rd1_d     = '0;
        rd2_d     = '0;
        signimm_d = '0;
        drive(1'b0, 32'h0, 1'b0, 10'h0);
        #2;
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 10'h0 || rd_e !== 5'd0 || stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL power_on_reset valid=%0b ctrl=%h rd=%0d stall=%0b", valid_e, ctrl_e, rd_e, stall_fd);
        end
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_capture();
        test_load_use();
        test_store_dep();
        test_cbz_no_ra();
        test_flush();
        test_back_to_back();
        test_xzr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
